// File: rtl/ball_physics_if.sv
// Bus between the ball physics engine and the game logic.
//   frame_tick     : one-cycle pulse, advance one physics step
//   paddleLeftPos  : [31:16] paddle left-edge x, [15:0] paddle center y
//   paddleRightPos : same format as paddleLeftPos
//   ballPosition   : [31:16] ball x (top-left), [15:0] ball y
//   ballVelocity   : [15:8] signed vx, [7:0] signed vy
//   playerDidScore : 01 left scored, 10 right scored (1-cycle pulse)
//   ball_update    : one-cycle pulse, ball outputs changed this cycle
// master drives the frame tick and paddles; slave is the physics engine.
interface ball_physics_if;
  logic        frame_tick;
  logic [31:0] paddleLeftPos;
  logic [31:0] paddleRightPos;
  logic [31:0] ballPosition;
  logic [15:0] ballVelocity;
  logic [1:0]  playerDidScore;
  logic        ball_update;

  modport master (
    output frame_tick, paddleLeftPos, paddleRightPos,
    input  ballPosition, ballVelocity, playerDidScore, ball_update
  );

  modport slave (
    input  frame_tick, paddleLeftPos, paddleRightPos,
    output ballPosition, ballVelocity, playerDidScore, ball_update
  );
endinterface

// File: rtl/ball_physics.sv
// Pong ball physics: serve delay, per-frame motion, wall and paddle bounces,
// miss detection with score pulse.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset, overrides every other input
//   bus : ball_physics_if.slave (frame tick and paddles in, ball state out)
// Optional feature macro: BALL_SPEEDUP_EN -- each paddle hit adds 1 to |vx|,
// saturating at MAX_VX. Without it |vx| stays INIT_VX for the whole rally.
module ball_physics #(
  parameter int SCREEN_W           = 640,
  parameter int SCREEN_H           = 480,
  parameter int BALL_SIZE          = 8,
  parameter int HALF_PADDLE_HEIGHT = 50,
  parameter int PADDLE_WIDTH       = 10,
  parameter int SERVE_DELAY        = 60,
  parameter int INIT_VX            = 4,
  parameter int INIT_VY            = 2,
  parameter int MAX_VX             = 12
) (
  input logic           clk,
  input logic           rst,
  ball_physics_if.slave bus
);

  typedef enum logic [1:0] {SERVE_WAIT, PLAY, SCORED} state_t;

  localparam logic [15:0]        CX      = 16'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [15:0]        CY      = 16'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [15:0]        DELAY   = 16'(SERVE_DELAY);
  localparam logic signed [7:0]  IVX     = 8'(INIT_VX);
  localparam logic signed [7:0]  IVY     = 8'(INIT_VY);
  // 19-bit compare domain: paddle x + width cannot overflow, 17-bit sums sign-extend.
  localparam logic signed [18:0] BS_W    = 19'(BALL_SIZE);
  localparam logic signed [18:0] HBS_W   = 19'(BALL_SIZE / 2);
  localparam logic signed [18:0] PW_W    = 19'(PADDLE_WIDTH);
  localparam logic signed [18:0] HPH_W   = 19'(HALF_PADDLE_HEIGHT);
  localparam logic signed [18:0] XLIM_W  = 19'(SCREEN_W - BALL_SIZE);
  localparam logic signed [18:0] YLIM_W  = 19'(SCREEN_H - BALL_SIZE);
`ifdef BALL_SPEEDUP_EN
  localparam logic signed [7:0]  MAXV    = 8'(MAX_VX);
`endif

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      x_q, x_d, y_q, y_d;
  logic signed [7:0] vx_q, vx_d, vy_q, vy_d;
  logic [1:0]       score_q, score_d;
  logic             upd_q, upd_d;
  // Serve direction: 0 serves toward +x, 1 toward -x (player who last conceded).
  logic             dir_q, dir_d;

  logic signed [16:0] nx, ny;
  logic signed [18:0] nx_w, ny_w, cy_w;
  logic signed [18:0] lx_w, ly_w, rx_w, ry_w, dl_w, dr_w;
  logic signed [18:0] lx_edge, rx_edge;
  logic               win_l, win_r, hit_l, hit_r, hit;
  logic               top, bot, miss_l, miss_r;
  logic signed [7:0]  abs_vx, mag_hit, vx_hit;

  // Motion and collision terms, evaluated every cycle but used only on a PLAY tick.
  always_comb begin
    nx   = {1'b0, x_q} + {{9{vx_q[7]}}, vx_q};
    ny   = {1'b0, y_q} + {{9{vy_q[7]}}, vy_q};
    nx_w = {{2{nx[16]}}, nx};
    ny_w = {{2{ny[16]}}, ny};
    cy_w = ny_w + HBS_W;

    lx_w = {3'b000, bus.paddleLeftPos[31:16]};
    ly_w = {3'b000, bus.paddleLeftPos[15:0]};
    rx_w = {3'b000, bus.paddleRightPos[31:16]};
    ry_w = {3'b000, bus.paddleRightPos[15:0]};
    dl_w = cy_w - ly_w;
    dr_w = cy_w - ry_w;
    win_l = (dl_w <= HPH_W) && (dl_w >= -HPH_W);
    win_r = (dr_w <= HPH_W) && (dr_w >= -HPH_W);

    lx_edge = lx_w + PW_W;
    rx_edge = rx_w - BS_W;
    hit_l = vx_q[7] && (nx_w <= lx_edge) && (nx_w + BS_W > lx_w) && win_l;
    hit_r = !vx_q[7] && (vx_q != 8'sd0) && (nx_w + BS_W >= rx_w) && (nx_w < rx_w + PW_W) &&
            win_r;
    hit   = hit_l || hit_r;

    top    = ny_w[18];
    bot    = ny_w > YLIM_W;
    miss_l = nx_w[18] && !hit;
    miss_r = (nx_w > XLIM_W) && !hit;

    abs_vx = vx_q[7] ? -vx_q : vx_q;
`ifdef BALL_SPEEDUP_EN
    mag_hit = (abs_vx >= MAXV) ? MAXV : abs_vx + 8'sd1;
`else
    mag_hit = abs_vx;
`endif
    // Reflect vx: the new sign is the opposite of the current one.
    vx_hit = vx_q[7] ? mag_hit : -mag_hit;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    score_d = 2'b00;
    upd_d   = 1'b0;
    dir_d   = dir_q;

    unique case (state_q)
      SERVE_WAIT: begin
        x_d  = CX;
        y_d  = CY;
        vx_d = 8'sd0;
        vy_d = 8'sd0;
        if (cnt_q == DELAY) begin
          state_d = PLAY;
          vx_d    = dir_q ? -IVX : IVX;
          vy_d    = IVY;
        end else if (bus.frame_tick) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      PLAY: begin
        if (bus.frame_tick) begin
          if (miss_l) begin
            score_d = 2'b10;
            dir_d   = 1'b1;
            state_d = SCORED;
          end else if (miss_r) begin
            score_d = 2'b01;
            dir_d   = 1'b0;
            state_d = SCORED;
          end else begin
            upd_d = 1'b1;
            if (hit_l) begin
              x_d  = lx_edge[15:0];
              vx_d = vx_hit;
            end else if (hit_r) begin
              x_d  = rx_edge[15:0];
              vx_d = vx_hit;
            end else begin
              x_d = nx[15:0];
            end
            if (top) begin
              y_d  = 16'd0;
              vy_d = -vy_q;
            end else if (bot) begin
              y_d  = YLIM_W[15:0];
              vy_d = -vy_q;
            end else begin
              y_d = ny[15:0];
            end
          end
        end
      end

      SCORED: begin
        x_d     = CX;
        y_d     = CY;
        vx_d    = 8'sd0;
        vy_d    = 8'sd0;
        cnt_d   = 16'd0;
        upd_d   = 1'b1;
        state_d = SERVE_WAIT;
      end

      default: begin
        state_d = SERVE_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SERVE_WAIT;
      cnt_q   <= 16'd0;
      x_q     <= CX;
      y_q     <= CY;
      vx_q    <= 8'sd0;
      vy_q    <= 8'sd0;
      score_q <= 2'b00;
      upd_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      score_q <= score_d;
      upd_q   <= upd_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.ballPosition   = {x_q, y_q};
  assign bus.ballVelocity   = {vx_q, vy_q};
  assign bus.playerDidScore = score_q;
  assign bus.ball_update    = upd_q;

endmodule

// File: tb/tb_ball_physics.sv
module tb_ball_physics;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ball_physics_if bus();

  ball_physics dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] CENTER = {16'd316, 16'd236};
  localparam logic [31:0] L_AWAY = {16'd20, 16'd1000};
  localparam logic [31:0] R_AWAY = {16'd620, 16'd1000};

  typedef struct {
    int          ticks;
    logic [31:0] lpad;
    logic [31:0] rpad;
    logic [31:0] pos;
    logic [15:0] vel;
  } row_t;

  row_t rows[11];
  int   nrows;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Each tick is preceded by one idle cycle; returns just after the tick's edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic serve();
    ticks(60);
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.frame_tick     = 1'b0;
    bus.paddleLeftPos  = L_AWAY;
    bus.paddleRightPos = R_AWAY;

    // Rally after a serve toward +x; positions hand-computed from (316,236), v=(4,2).
    rows[0] = '{1,   L_AWAY, R_AWAY, {16'd320, 16'd238}, 16'h0402};
    rows[1] = '{72,  L_AWAY, R_AWAY, {16'd608, 16'd382}, 16'h0402};
`ifndef BALL_SPEEDUP_EN
    rows[2]  = '{1,   L_AWAY, {16'd620, 16'd388}, {16'd612, 16'd384}, 16'hFC02};
    rows[3]  = '{44,  L_AWAY, {16'd620, 16'd388}, {16'd436, 16'd472}, 16'hFC02};
    rows[4]  = '{1,   L_AWAY, {16'd620, 16'd388}, {16'd432, 16'd472}, 16'hFCFE};
    rows[5]  = '{100, L_AWAY, R_AWAY, {16'd32, 16'd272}, 16'hFCFE};
    rows[6]  = '{1,   {16'd20, 16'd274}, R_AWAY, {16'd30, 16'd270}, 16'h04FE};
    rows[7]  = '{134, L_AWAY, {16'd582, 16'd1000}, {16'd566, 16'd2}, 16'h04FE};
    rows[8]  = '{1,   L_AWAY, {16'd582, 16'd5}, {16'd570, 16'd0}, 16'h04FE};
    // Top wall and right paddle in the same step.
    rows[9]  = '{1,   L_AWAY, {16'd582, 16'd5}, {16'd574, 16'd0}, 16'hFC02};
    rows[10] = '{143, L_AWAY, {16'd582, 16'd5}, {16'd2, 16'd286}, 16'hFC02};
    nrows = 11;
`else
    rows[2] = '{1,   L_AWAY, {16'd620, 16'd388}, {16'd612, 16'd384}, 16'hFB02};
    rows[3] = '{44,  L_AWAY, {16'd620, 16'd388}, {16'd392, 16'd472}, 16'hFB02};
    rows[4] = '{1,   L_AWAY, {16'd620, 16'd388}, {16'd387, 16'd472}, 16'hFBFE};
    rows[5] = '{71,  L_AWAY, R_AWAY, {16'd32, 16'd330}, 16'hFBFE};
    rows[6] = '{1,   {16'd20, 16'd332}, R_AWAY, {16'd30, 16'd328}, 16'h06FE};
    nrows = 7;
`endif

    do_reset();
    chk("rst_pos", bus.ballPosition, CENTER);
    chk("rst_vel", {16'd0, bus.ballVelocity}, 32'h0);
    chk("rst_score", {30'd0, bus.playerDidScore}, 32'h0);
    chk("rst_upd", {31'd0, bus.ball_update}, 32'h0);

    // One tick short of the serve delay: still waiting.
    ticks(59);
    cyc();
    cyc();
    chk("serve_early_vel", {16'd0, bus.ballVelocity}, 32'h0);
    ticks(1);
    cyc();
    chk("serve_vel", {16'd0, bus.ballVelocity}, 32'h0402);
    chk("serve_pos", bus.ballPosition, CENTER);

    // Right miss with paddles out of reach.
    ticks(79);
    chk("edge_pos", bus.ballPosition, {16'd632, 16'd394});
    chk("edge_upd", {31'd0, bus.ball_update}, 32'h1);
    ticks(1);
    chk("miss_r_score", {30'd0, bus.playerDidScore}, 32'h1);
    cyc();
    chk("miss_r_score_end", {30'd0, bus.playerDidScore}, 32'h0);
    chk("miss_r_pos", bus.ballPosition, CENTER);
    chk("miss_r_vel", {16'd0, bus.ballVelocity}, 32'h0);
    serve();
    chk("serve_after_r", {16'd0, bus.ballVelocity}, 32'h0402);

    for (int i = 0; i < nrows; i++) begin
      bus.paddleLeftPos  = rows[i].lpad;
      bus.paddleRightPos = rows[i].rpad;
      ticks(rows[i].ticks);
      chk($sformatf("row%0d_pos", i), bus.ballPosition, rows[i].pos);
      chk($sformatf("row%0d_vel", i), {16'd0, bus.ballVelocity}, {16'd0, rows[i].vel});
      chk($sformatf("row%0d_upd", i), {31'd0, bus.ball_update}, 32'h1);
      chk($sformatf("row%0d_score", i), {30'd0, bus.playerDidScore}, 32'h0);
    end
    bus.paddleLeftPos  = L_AWAY;
    bus.paddleRightPos = R_AWAY;

`ifndef BALL_SPEEDUP_EN
    // Ball at (2,286) moving -x: next tick misses left.
    ticks(1);
    chk("miss_l_score", {30'd0, bus.playerDidScore}, 32'h2);
    cyc();
    chk("miss_l_score_end", {30'd0, bus.playerDidScore}, 32'h0);
    chk("miss_l_pos", bus.ballPosition, CENTER);
    chk("miss_l_vel", {16'd0, bus.ballVelocity}, 32'h0);
    serve();
    chk("serve_after_l", {16'd0, bus.ballVelocity}, 32'hFC02);
    ticks(1);
    chk("serve_l_step", bus.ballPosition, {16'd312, 16'd238});
    chk("serve_l_upd", {31'd0, bus.ball_update}, 32'h1);
    cyc();
    chk("upd_one_cycle", {31'd0, bus.ball_update}, 32'h0);
`endif

    // Reset coinciding with a frame tick mid-rally.
    cyc();
    bus.frame_tick = 1'b1;
    rst = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    rst = 1'b0;
    chk("rst_mid_pos", bus.ballPosition, CENTER);
    chk("rst_mid_vel", {16'd0, bus.ballVelocity}, 32'h0);
    chk("rst_mid_score", {30'd0, bus.playerDidScore}, 32'h0);
    chk("rst_mid_upd", {31'd0, bus.ball_update}, 32'h0);
    serve();
    chk("serve_after_rst", {16'd0, bus.ballVelocity}, 32'h0402);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_physics.md
BALL_PHYSICS -- requirements
Module: ball_physics

Interface
REQ-001 SHALL have parameters: SCREEN_W, default 640, playfield width in pixels.
REQ-002 SHALL have parameters: SCREEN_H, default 480, playfield height; BALL_SIZE, default 8, ball edge length.
REQ-003 SHALL have parameters: HALF_PADDLE_HEIGHT, default 50, paddle half-height; PADDLE_WIDTH, default 10, paddle width.
REQ-004 SHALL have parameters: SERVE_DELAY, default 60, frames before a serve; INIT_VX, default 4; INIT_VY, default 2; MAX_VX, default 12.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse, advance one physics step.
- paddleLeftPos  in  32  [31:16] paddle left-edge x, [15:0] paddle center y.
- paddleRightPos  in  32  same format as paddleLeftPos.
- ballPosition  out  32  [31:16] ball x (top-left), [15:0] ball y.
- ballVelocity  out  16  [15:8] signed vx, [7:0] signed vy.
- playerDidScore  out  2  01 = left scored, 10 = right scored; 1-cycle pulse.
- ball_update  out  1  one-cycle pulse; outputs were updated this cycle.

Function
REQ-007 SHALL implement FSM states SERVE_WAIT, PLAY, SCORED.
REQ-008 SERVE_WAIT SHALL keep the ball centered with velocity 0 and count frame_ticks.
REQ-009 When the SERVE_WAIT count reaches SERVE_DELAY, the next cycle SHALL be PLAY, with vy=+INIT_VY and vx=±INIT_VX signed toward the player who last conceded (+INIT_VX after reset).
REQ-010 In PLAY, each frame_tick SHALL compute nx=x+vx and ny=y+vy in 17-bit signed arithmetic (sign-extended velocity, no wrap).
- Result registered 1 cycle after frame_tick; ball_update asserted that cycle.
REQ-011 Top wall: ny<0 SHALL give y=0, vy=-vy.
REQ-012 Bottom wall: ny>SCREEN_H-BALL_SIZE SHALL give y=SCREEN_H-BALL_SIZE, vy=-vy.
REQ-013 Left paddle hit: vx<0, nx<=leftX+PADDLE_WIDTH, nx+BALL_SIZE>leftX, and |ball center y - leftY|<=HALF_PADDLE_HEIGHT SHALL give x=leftX+PADDLE_WIDTH, vx=-vx.
REQ-014 Right paddle hit: vx>0, nx+BALL_SIZE>=rightX, nx<rightX+PADDLE_WIDTH, and the same y window SHALL give x=rightX-BALL_SIZE, vx=-vx.
REQ-015 A paddle hit SHALL take precedence over a miss; a wall bounce and a paddle hit in the same step SHALL both apply.
REQ-016 Miss: nx<0 without a hit SHALL pulse playerDidScore=10; nx>SCREEN_W-BALL_SIZE without a hit SHALL pulse 01.
- Then enter SCORED.
REQ-017 SCORED SHALL last exactly one cycle: recenter the ball, zero the velocity, clear the serve counter, go to SERVE_WAIT.
REQ-018 frame_tick outside the defined states SHALL have no effect; playerDidScore SHALL be 00 except during its pulse.

Reset
REQ-019 rst SHALL override all other inputs on the same clock edge, including mid-PLAY.
REQ-020 After rst: state SERVE_WAIT, counter 0, ballPosition={SCREEN_W/2-BALL_SIZE/2, SCREEN_H/2-BALL_SIZE/2} (316,236 default), ballVelocity=0, playerDidScore=00, ball_update=0, next serve direction +x.

Configuration
REQ-021 BALL_SPEEDUP_EN defined: each paddle hit SHALL increase |vx| by 1, saturating at MAX_VX.
REQ-022 BALL_SPEEDUP_EN undefined: |vx| SHALL stay INIT_VX for the whole rally.

Verification
REQ-023 Reset, then 60 frame_ticks -> PLAY; next tick gives ballPosition=(320,238), ballVelocity=(+4,+2), ball_update pulse.
REQ-024 Ball y=1, vy=-2, tick -> y=0, vy=+2; ball y=471, vy=+2 -> y=472, vy=-2.
REQ-025 Left paddle (20,240), ball (32,236), vx=-4 -> x=30, vx=+4 (+5 with BALL_SPEEDUP_EN).
REQ-026 Left paddle y=100, ball (2,400), vx=-4 -> playerDidScore=10 for 1 cycle, ball recentered, next serve vx=-4.
REQ-027 Corner case: ball (630,1), vx=+4, vy=-2, right paddle (632,5) -> vx=-4, vy=+2, x=624, y=0, no score.
REQ-028 rst asserted on the same cycle as frame_tick mid-rally -> all REQ-020 values next cycle, no ball_update.
